// File: rtl/sirius_fetch_pkg.sv
// Shared types for the instruction fetch slice: FSM states, response record and PC stepping.
package sirius_fetch_pkg;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_KILL} fetch_state_t;

  localparam int unsigned FETCH_BYTES = 8;

  typedef struct packed {
    logic [63:0] data;
    logic [31:0] pc;
  } fetch_resp_t;

  // Next fetch block: align down to the 64-bit fetch unit, then step; wraps at 2^32.
  function automatic logic [31:0] next_fetch_pc(input logic [31:0] pc);
    return {pc[31:3], 3'b000} + 32'(FETCH_BYTES);
  endfunction

endpackage

// File: rtl/fetch_hold_buffer.sv
// One-entry holding register for a response that arrived while the FIFO was full.
module fetch_hold_buffer
  import sirius_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  fetch_resp_t load_data,
  output logic        valid,
  output fetch_resp_t data
);

  logic        valid_reg;
  fetch_resp_t data_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (clear) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= load_data;
    end
  end

  assign valid = valid_reg;
  assign data  = data_reg;

endmodule

// File: rtl/fetch_controller.sv
// Fetch sequencer feeding the dual-write instruction FIFO, with redirect flush/kill handling.
// Optional FETCH_PERF_EN adds request/kill/stall counters.
module fetch_controller
  import sirius_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        redirect_keep_delay,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [63:0] imem_rdata,
  input  logic        fifo_full,
  output logic        fifo_flush,
  output logic        fifo_flush_delay,
  output logic        fifo_write_en1,
  output logic        fifo_write_en2,
  output logic [31:0] fifo_write_data1,
  output logic [31:0] fifo_write_addr1,
  output logic [31:0] fifo_write_data2,
  output logic [31:0] fifo_write_addr2,
  output logic [31:0] fetch_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_req_cnt,
  output logic [31:0] perf_kill_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  fetch_state_t state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic         hold_load, hold_clear, hold_valid;
  fetch_resp_t  hold_data, write_src;
  logic         write_fire;

  fetch_hold_buffer u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (hold_load),
    .clear     (hold_clear),
    .load_data ('{data: imem_rdata, pc: pc_reg}),
    .valid     (hold_valid),
    .data      (hold_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      pc_reg    <= RESET_PC;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    hold_load        = 1'b0;
    hold_clear       = 1'b0;
    write_fire       = 1'b0;
    write_src        = '0;
    imem_req         = 1'b0;
    imem_addr        = '0;
    fifo_flush       = 1'b0;
    fifo_flush_delay = 1'b0;
    fifo_write_en1   = 1'b0;
    fifo_write_en2   = 1'b0;
    fifo_write_data1 = '0;
    fifo_write_addr1 = '0;
    fifo_write_data2 = '0;
    fifo_write_addr2 = '0;

    case (state_reg)
      S_IDLE: if (!fifo_full) state_next = S_REQ;
      S_REQ: begin
        imem_req  = 1'b1;
        imem_addr = {pc_reg[31:3], 3'b000};
        if (imem_gnt) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          pc_next = next_fetch_pc(pc_reg);
          if (!fifo_full) begin
            write_fire = 1'b1;
            write_src  = '{data: imem_rdata, pc: pc_reg};
            state_next = S_REQ;
          end else begin
            hold_load  = 1'b1;
            state_next = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!fifo_full && hold_valid) begin
          write_fire = 1'b1;
          write_src  = hold_data;
          hold_clear = 1'b1;
          state_next = S_REQ;
        end
      end
      S_KILL: if (imem_rvalid) state_next = S_REQ;
      default: state_next = S_IDLE;
    endcase

    // A redirect overrides everything; a response already owed by memory must be killed later.
    if (redirect_valid) begin
      fifo_flush       = 1'b1;
      fifo_flush_delay = redirect_keep_delay;
      write_fire       = 1'b0;
      hold_load        = 1'b0;
      hold_clear       = 1'b1;
      pc_next          = redirect_pc;
      if ((state_reg == S_WAIT && !imem_rvalid) ||
          (state_reg == S_REQ  && imem_gnt)     ||
          (state_reg == S_KILL && !imem_rvalid))
        state_next = S_KILL;
      else
        state_next = S_REQ;
    end

    if (write_fire) begin
      fifo_write_en1   = 1'b1;
      fifo_write_addr1 = write_src.pc;
      if (!write_src.pc[2]) begin
        fifo_write_en2   = 1'b1;
        fifo_write_data1 = write_src.data[31:0];
        fifo_write_data2 = write_src.data[63:32];
        fifo_write_addr2 = write_src.pc + 32'd4;
      end else begin
        fifo_write_data1 = write_src.data[63:32];
      end
    end
  end

  assign fetch_pc = pc_reg;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_req_reg, perf_kill_reg, perf_stall_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_req_reg   <= '0;
      perf_kill_reg  <= '0;
      perf_stall_reg <= '0;
    end else begin
      if (state_reg == S_REQ && imem_gnt) perf_req_reg <= perf_req_reg + 32'd1;
      if (imem_rvalid && (state_reg == S_KILL || (state_reg == S_WAIT && redirect_valid)))
        perf_kill_reg <= perf_kill_reg + 32'd1;
      if (state_reg == S_HOLD) perf_stall_reg <= perf_stall_reg + 32'd1;
    end
  end

  assign perf_req_cnt   = perf_req_reg;
  assign perf_kill_cnt  = perf_kill_reg;
  assign perf_stall_cnt = perf_stall_reg;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Directed-vector bench for fetch_controller: fetch, redirect, full backoff, kill and wrap.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_keep_delay;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [63:0] imem_rdata;
  logic        fifo_full;
  logic        fifo_flush;
  logic        fifo_flush_delay;
  logic        fifo_write_en1;
  logic        fifo_write_en2;
  logic [31:0] fifo_write_data1;
  logic [31:0] fifo_write_addr1;
  logic [31:0] fifo_write_data2;
  logic [31:0] fifo_write_addr2;
  logic [31:0] fetch_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_req_cnt, perf_kill_cnt, perf_stall_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fetch_controller #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .redirect_keep_delay (redirect_keep_delay),
    .imem_req            (imem_req),
    .imem_addr           (imem_addr),
    .imem_gnt            (imem_gnt),
    .imem_rvalid         (imem_rvalid),
    .imem_rdata          (imem_rdata),
    .fifo_full           (fifo_full),
    .fifo_flush          (fifo_flush),
    .fifo_flush_delay    (fifo_flush_delay),
    .fifo_write_en1      (fifo_write_en1),
    .fifo_write_en2      (fifo_write_en2),
    .fifo_write_data1    (fifo_write_data1),
    .fifo_write_addr1    (fifo_write_addr1),
    .fifo_write_data2    (fifo_write_data2),
    .fifo_write_addr2    (fifo_write_addr2),
    .fetch_pc            (fetch_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_req_cnt        (perf_req_cnt),
    .perf_kill_cnt       (perf_kill_cnt),
    .perf_stall_cnt      (perf_stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Advance one cycle; inputs are then applied 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; redirect_keep_delay = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; fifo_full = 1'b0;
    step(); step();
    settle();
    check("rst_req", imem_req, 0);
    check("rst_fetch_pc", fetch_pc, 32'hBFC0_0000);
    check("rst_flush", fifo_flush, 0);
    check("rst_we1", fifo_write_en1, 0);

    // 1: first fetch after reset, aligned pc -> two writes
    rst_n = 1'b1;
    step();                                   // S_IDLE -> S_REQ
    settle();
    check("t1_req", imem_req, 1);
    check("t1_addr", imem_addr, 32'hBFC0_0000);
    imem_gnt = 1'b1;
    step(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 64'h1111_1111_2222_2222;
    settle();
    check("t1_en1", fifo_write_en1, 1);
    check("t1_en2", fifo_write_en2, 1);
    check("t1_data1", fifo_write_data1, 32'h2222_2222);
    check("t1_addr1", fifo_write_addr1, 32'hBFC0_0000);
    check("t1_data2", fifo_write_data2, 32'h1111_1111);
    check("t1_addr2", fifo_write_addr2, 32'hBFC0_0004);
    step(); imem_rvalid = 1'b0;
    settle();
    check("t1_next_addr", imem_addr, 32'hBFC0_0008);

    // 2: redirect to an odd-word target -> single write from upper half
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0014; redirect_keep_delay = 1'b0;
    settle();
    check("t2_flush", fifo_flush, 1);
    check("t2_flush_delay", fifo_flush_delay, 0);
    step(); redirect_valid = 1'b0;
    settle();
    check("t2_addr", imem_addr, 32'h8000_0010);
    imem_gnt = 1'b1;
    step(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 64'hAAAA_AAAA_BBBB_BBBB;
    settle();
    check("t2_en1", fifo_write_en1, 1);
    check("t2_en2", fifo_write_en2, 0);
    check("t2_data1", fifo_write_data1, 32'hAAAA_AAAA);
    check("t2_addr1", fifo_write_addr1, 32'h8000_0014);
    check("t2_data2", fifo_write_data2, 0);
    step(); imem_rvalid = 1'b0;
    settle();
    check("t2_next_addr", imem_addr, 32'h8000_0018);

    // 3: response arrives while full -> held, written when full drops
    imem_gnt = 1'b1;
    step(); imem_gnt = 1'b0;
    fifo_full = 1'b1; imem_rvalid = 1'b1; imem_rdata = 64'h3333_3333_4444_4444;
    settle();
    check("t3_no_write", fifo_write_en1, 0);
    step(); imem_rvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("t3_hold_we1", fifo_write_en1, 0);
      check("t3_hold_req", imem_req, 0);
      step();
    end
    fifo_full = 1'b0;
    settle();
    check("t3_en1", fifo_write_en1, 1);
    check("t3_en2", fifo_write_en2, 1);
    check("t3_data1", fifo_write_data1, 32'h4444_4444);
    check("t3_addr1", fifo_write_addr1, 32'h8000_0018);
    check("t3_data2", fifo_write_data2, 32'h3333_3333);
    check("t3_addr2", fifo_write_addr2, 32'h8000_001C);
    step();
    settle();
    check("t3_req", imem_req, 1);
    check("t3_addr", imem_addr, 32'h8000_0020);

    // 4: redirect while waiting, keep delay slot -> stale response killed
    imem_gnt = 1'b1;
    step(); imem_gnt = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100; redirect_keep_delay = 1'b1;
    settle();
    check("t4_flush", fifo_flush, 1);
    check("t4_flush_delay", fifo_flush_delay, 1);
    step(); redirect_valid = 1'b0; redirect_keep_delay = 1'b0;
    settle();
    check("t4_flush_off", fifo_flush, 0);
    check("t4_kill_req", imem_req, 0);
    imem_rvalid = 1'b1; imem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    settle();
    check("t4_stale_we1", fifo_write_en1, 0);
    step(); imem_rvalid = 1'b0;
    settle();
    check("t4_addr", imem_addr, 32'h8000_0100);
    imem_gnt = 1'b1;
    step(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 64'h5555_5555_6666_6666;
    settle();
    check("t4_addr1", fifo_write_addr1, 32'h8000_0100);
    check("t4_data1", fifo_write_data1, 32'h6666_6666);
    step(); imem_rvalid = 1'b0;

    // 5: redirect with coincident gnt, second redirect two cycles later
    settle();
    check("t5_addr", imem_addr, 32'h8000_0108);
    redirect_valid = 1'b1; redirect_pc = 32'h9000_0000; imem_gnt = 1'b1;
    step(); redirect_valid = 1'b0; imem_gnt = 1'b0;
    settle();
    check("t5_kill_req", imem_req, 0);
    step();
    redirect_valid = 1'b1; redirect_pc = 32'hA000_0004;
    step(); redirect_valid = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 64'hCAFE_CAFE_CAFE_CAFE;
    settle();
    check("t5_stale_we1", fifo_write_en1, 0);
    step(); imem_rvalid = 1'b0;
    settle();
    check("t5_req", imem_req, 1);
    check("t5_addr2", imem_addr, 32'hA000_0000);
    check("t5_fetch_pc", fetch_pc, 32'hA000_0004);
    imem_gnt = 1'b1;
    step(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 64'h7777_7777_8888_8888;
    settle();
    check("t5_en1", fifo_write_en1, 1);
    check("t5_en2", fifo_write_en2, 0);
    check("t5_data1", fifo_write_data1, 32'h7777_7777);
    check("t5_addr1", fifo_write_addr1, 32'hA000_0004);
    step(); imem_rvalid = 1'b0;

    // 6: fetch at top of address space wraps to zero
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step(); redirect_valid = 1'b0;
    settle();
    check("t6_addr", imem_addr, 32'hFFFF_FFF8);
    imem_gnt = 1'b1;
    step(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 64'h0123_4567_89AB_CDEF;
    settle();
    check("t6_addr2", fifo_write_addr2, 32'hFFFF_FFFC);
    step(); imem_rvalid = 1'b0;
    settle();
    check("t6_wrap_addr", imem_addr, 32'h0000_0000);
    check("t6_wrap_pc", fetch_pc, 32'h0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
